// File: rtl/grant_dst_router.sv
// 1-to-4 grant channel demultiplexer: a 2-entry register FIFO feeds four client ports,
// with multi-beat data grants locked to one destination until the last beat leaves.
module grant_dst_router #(
    parameter int DATA_BEATS = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [1:0]  io_in_bits_header_src,
    input  logic [1:0]  io_in_bits_header_dst,
    input  logic [2:0]  io_in_bits_payload_addr_beat,
    input  logic        io_in_bits_payload_client_xact_id,
    input  logic [1:0]  io_in_bits_payload_manager_xact_id,
    input  logic        io_in_bits_payload_is_builtin_type,
    input  logic [3:0]  io_in_bits_payload_g_type,
    input  logic [63:0] io_in_bits_payload_data,

    output logic        io_out_0_valid,
    input  logic        io_out_0_ready,
    output logic        io_out_1_valid,
    input  logic        io_out_1_ready,
    output logic        io_out_2_valid,
    input  logic        io_out_2_ready,
    output logic        io_out_3_valid,
    input  logic        io_out_3_ready,

    output logic [1:0]  io_out_bits_header_src,
    output logic [1:0]  io_out_bits_header_dst,
    output logic [2:0]  io_out_bits_payload_addr_beat,
    output logic        io_out_bits_payload_client_xact_id,
    output logic [1:0]  io_out_bits_payload_manager_xact_id,
    output logic        io_out_bits_payload_is_builtin_type,
    output logic [3:0]  io_out_bits_payload_g_type,
    output logic [63:0] io_out_bits_payload_data,

    output logic        io_locked,
    output logic [1:0]  io_lock_dst,
    output logic        io_err
);

    localparam int CNT_W = $clog2(DATA_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [1:0] FIFO_FULL = 2'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [2:0]  addr_beat;
        logic        client_xact_id;
        logic [1:0]  manager_xact_id;
        logic        is_builtin_type;
        logic [3:0]  g_type;
        logic [63:0] data;
    } beat_t;

    beat_t            mem_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             locked_q, locked_d;
    logic [1:0]       lock_dst_q, lock_dst_d;
    logic             err_q, err_d;

    beat_t      in_beat;
    beat_t      head;
    logic       enq;
    logic       deq;
    logic       head_has_data;
    logic [1:0] sel;
    logic [3:0] out_ready_vec;
    logic [3:0] out_valid_vec;
    logic [CNT_W-1:0] beat_cnt_inc;

    assign in_beat = '{
        src:             io_in_bits_header_src,
        dst:             io_in_bits_header_dst,
        addr_beat:       io_in_bits_payload_addr_beat,
        client_xact_id:  io_in_bits_payload_client_xact_id,
        manager_xact_id: io_in_bits_payload_manager_xact_id,
        is_builtin_type: io_in_bits_payload_is_builtin_type,
        g_type:          io_in_bits_payload_g_type,
        data:            io_in_bits_payload_data
    };

    // Ready comes from registered occupancy only, so it never combinationally follows a port ready.
    assign io_in_ready = (count_q < FIFO_FULL);
    assign enq         = io_in_valid & io_in_ready;

    assign head          = mem_q[rd_ptr_q];
    assign head_has_data = head.is_builtin_type ? (head.g_type == 4'h5) : (head.g_type == 4'h0);

    assign sel           = locked_q ? lock_dst_q : head.dst;
    assign out_ready_vec = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
    assign out_valid_vec = (count_q != 2'd0) ? (4'b0001 << sel) : 4'b0000;
    assign deq           = (count_q != 2'd0) & out_ready_vec[sel];

    assign {io_out_3_valid, io_out_2_valid, io_out_1_valid, io_out_0_valid} = out_valid_vec;

    assign io_out_bits_header_src              = head.src;
    assign io_out_bits_header_dst              = head.dst;
    assign io_out_bits_payload_addr_beat       = head.addr_beat;
    assign io_out_bits_payload_client_xact_id  = head.client_xact_id;
    assign io_out_bits_payload_manager_xact_id = head.manager_xact_id;
    assign io_out_bits_payload_is_builtin_type = head.is_builtin_type;
    assign io_out_bits_payload_g_type          = head.g_type;
    assign io_out_bits_payload_data            = head.data;

    assign io_locked   = locked_q;
    assign io_lock_dst = lock_dst_q;
    assign io_err      = err_q;

    assign beat_cnt_inc = beat_cnt_q + CNT_ONE;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = ~wr_ptr_q;
        if (deq) rd_ptr_d = ~rd_ptr_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Off-lock beats are still delivered to the locked port and counted; only the error flag records them.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        locked_d   = locked_q;
        lock_dst_d = lock_dst_q;
        err_d      = err_q;
        if (deq) begin
            if (locked_q) begin
                beat_cnt_d = beat_cnt_inc;
                if (beat_cnt_inc == '0) locked_d = 1'b0;
                if (!head_has_data || (head.dst != lock_dst_q)) err_d = 1'b1;
            end else if (head_has_data) begin
                beat_cnt_d = CNT_ONE;
                lock_dst_d = head.dst;
                locked_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            beat_cnt_q <= '0;
            locked_q   <= 1'b0;
            lock_dst_q <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            if (enq) mem_q[wr_ptr_q] <= in_beat;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            locked_q   <= locked_d;
            lock_dst_q <= lock_dst_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_grant_dst_router.sv
// Directed bench for grant_dst_router: routing, bursts, backpressure, lock errors and async reset.
module tb_grant_dst_router;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_src = '0;
    logic [1:0]  in_dst = '0;
    logic [2:0]  in_beat = '0;
    logic        in_cid = 1'b0;
    logic [1:0]  in_mid = '0;
    logic        in_builtin = 1'b0;
    logic [3:0]  in_gtype = '0;
    logic [63:0] in_data = '0;
    logic        v0, v1, v2, v3;
    logic        r0 = 1'b1, r1 = 1'b1, r2 = 1'b1, r3 = 1'b1;
    logic [1:0]  o_src, o_dst, o_mid;
    logic [2:0]  o_beat;
    logic        o_cid, o_builtin;
    logic [3:0]  o_gtype;
    logic [63:0] o_data;
    logic        locked, err;
    logic [1:0]  lock_dst;

    int n_chk = 0;
    int n_pass = 0;

    wire [3:0] vld = {v3, v2, v1, v0};

    grant_dst_router dut (
        .clk(clk), .reset_n(reset_n),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_bits_header_src(in_src), .io_in_bits_header_dst(in_dst),
        .io_in_bits_payload_addr_beat(in_beat),
        .io_in_bits_payload_client_xact_id(in_cid),
        .io_in_bits_payload_manager_xact_id(in_mid),
        .io_in_bits_payload_is_builtin_type(in_builtin),
        .io_in_bits_payload_g_type(in_gtype),
        .io_in_bits_payload_data(in_data),
        .io_out_0_valid(v0), .io_out_0_ready(r0),
        .io_out_1_valid(v1), .io_out_1_ready(r1),
        .io_out_2_valid(v2), .io_out_2_ready(r2),
        .io_out_3_valid(v3), .io_out_3_ready(r3),
        .io_out_bits_header_src(o_src), .io_out_bits_header_dst(o_dst),
        .io_out_bits_payload_addr_beat(o_beat),
        .io_out_bits_payload_client_xact_id(o_cid),
        .io_out_bits_payload_manager_xact_id(o_mid),
        .io_out_bits_payload_is_builtin_type(o_builtin),
        .io_out_bits_payload_g_type(o_gtype),
        .io_out_bits_payload_data(o_data),
        .io_locked(locked), .io_lock_dst(lock_dst), .io_err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] dst, input logic builtin, input logic [3:0] gt,
                         input logic [63:0] data);
        in_valid   = 1'b1;
        in_dst     = dst;
        in_builtin = builtin;
        in_gtype   = gt;
        in_data    = data;
        in_beat    = data[2:0];
        in_src     = 2'd1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        n_chk++; if (vld !== 4'b0000) $display("FAIL reset_valid: got %b want 0000", vld); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_chk++; if (lock_dst !== 2'd0) $display("FAIL reset_lock_dst: got %0d want 0", lock_dst); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single_route();
        logic [3:0] exp_v;
        r0 = 1; r1 = 1; r2 = 1; r3 = 1;
        tick();
        for (int d = 0; d < 4; d++) begin
            drive(2'(d), 1'b1, 4'h1, 64'(100 + d));
            tick();
            in_valid = 1'b0;
            exp_v = 4'b0001 << d;
            n_chk++; if (vld !== exp_v) $display("FAIL single_valid[%0d]: got %b want %b", d, vld, exp_v); else n_pass++;
            n_chk++; if (o_data !== 64'(100 + d)) $display("FAIL single_data[%0d]: got %0d want %0d", d, o_data, 100 + d); else n_pass++;
            tick();
            n_chk++; if (locked !== 1'b0) $display("FAIL single_locked[%0d]: got %b want 0", d, locked); else n_pass++;
        end
        n_chk++; if (vld !== 4'b0000) $display("FAIL single_drained: got %b want 0000", vld); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL single_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_burst();
        r0 = 0; r1 = 0; r2 = 1; r3 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(2'd2, 1'b0, 4'h0, 64'(i));
            tick();
            n_chk++; if (vld !== 4'b0100) $display("FAIL burst_valid[%0d]: got %b want 0100", i, vld); else n_pass++;
            n_chk++; if (o_data !== 64'(i)) $display("FAIL burst_data[%0d]: got %0d want %0d", i, o_data, i); else n_pass++;
            n_chk++; if (locked !== (i > 0)) $display("FAIL burst_locked[%0d]: got %b want %b", i, locked, i > 0); else n_pass++;
            if (i > 0) begin
                n_chk++; if (lock_dst !== 2'd2) $display("FAIL burst_lock_dst[%0d]: got %0d want 2", i, lock_dst); else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick();
        n_chk++; if (locked !== 1'b0) $display("FAIL burst_unlock: got %b want 0", locked); else n_pass++;
        n_chk++; if (vld !== 4'b0000) $display("FAIL burst_drained: got %b want 0000", vld); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL burst_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_backpressure();
        r0 = 1; r1 = 0; r2 = 1; r3 = 1;
        drive(2'd1, 1'b1, 4'h1, 64'hA1);
        tick();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_ready_1: got %b want 1", in_ready); else n_pass++;
        drive(2'd1, 1'b1, 4'h1, 64'hB2);
        tick();
        n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else n_pass++;
        drive(2'd1, 1'b1, 4'h1, 64'hC3);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_ready_hold[%0d]: got %b want 0", k, in_ready); else n_pass++;
            n_chk++; if (vld !== 4'b0010) $display("FAIL bp_valid_hold[%0d]: got %b want 0010", k, vld); else n_pass++;
            n_chk++; if (o_data !== 64'hA1) $display("FAIL bp_data_hold[%0d]: got %0h want a1", k, o_data); else n_pass++;
        end
        r1 = 1;
        tick();
        n_chk++; if (o_data !== 64'hB2) $display("FAIL bp_drain_b: got %0h want b2", o_data); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_chk++; if (o_data !== 64'hC3) $display("FAIL bp_drain_c: got %0h want c3", o_data); else n_pass++;
        n_chk++; if (vld !== 4'b0010) $display("FAIL bp_valid_c: got %b want 0010", vld); else n_pass++;
        tick();
        n_chk++; if (vld !== 4'b0000) $display("FAIL bp_drained: got %b want 0000", vld); else n_pass++;
    endtask

    task automatic test_dst_mismatch();
        r0 = 1; r1 = 1; r2 = 1; r3 = 1;
        for (int i = 0; i < 8; i++) begin
            drive((i == 3) ? 2'd3 : 2'd0, 1'b0, 4'h0, 64'(16 + i));
            tick();
            n_chk++; if (vld !== 4'b0001) $display("FAIL mm_valid[%0d]: got %b want 0001", i, vld); else n_pass++;
            n_chk++; if (o_data !== 64'(16 + i)) $display("FAIL mm_data[%0d]: got %0d want %0d", i, o_data, 16 + i); else n_pass++;
            n_chk++; if (err !== (i >= 4)) $display("FAIL mm_err[%0d]: got %b want %b", i, err, i >= 4); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_chk++; if (locked !== 1'b0) $display("FAIL mm_unlock: got %b want 0", locked); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL mm_err_sticky: got %b want 1", err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(2'd1, 1'b0, 4'h0, 64'(32 + i));
            tick();
            n_chk++; if (vld !== 4'b0010) $display("FAIL b2b_valid[%0d]: got %b want 0010", i, vld); else n_pass++;
        end
        drive(2'd3, 1'b1, 4'h1, 64'h55);
        tick();
        in_valid = 1'b0;
        n_chk++; if (vld !== 4'b1000) $display("FAIL b2b_single_valid: got %b want 1000", vld); else n_pass++;
        n_chk++; if (o_data !== 64'h55) $display("FAIL b2b_single_data: got %0h want 55", o_data); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL b2b_unlock: got %b want 0", locked); else n_pass++;
        tick();
        n_chk++; if (vld !== 4'b0000) $display("FAIL b2b_drained: got %b want 0000", vld); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL b2b_err_sticky: got %b want 1", err); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(2'd2, 1'b0, 4'h0, 64'(48 + i));
            tick();
        end
        n_chk++; if (locked !== 1'b1) $display("FAIL ar_locked_before: got %b want 1", locked); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++; if (vld !== 4'b0000) $display("FAIL ar_valid: got %b want 0000", vld); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL ar_locked: got %b want 0", locked); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL ar_err: got %b want 0", err); else n_pass++;
        in_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        drive(2'd2, 1'b1, 4'h1, 64'h77);
        tick();
        in_valid = 1'b0;
        n_chk++; if (vld !== 4'b0100) $display("FAIL ar_route_valid: got %b want 0100", vld); else n_pass++;
        n_chk++; if (o_data !== 64'h77) $display("FAIL ar_route_data: got %0h want 77", o_data); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL ar_route_locked: got %b want 0", locked); else n_pass++;
        tick();
        n_chk++; if (vld !== 4'b0000) $display("FAIL ar_drained: got %b want 0000", vld); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_burst();
        test_backpressure();
        test_dst_mismatch();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/grant_dst_router.md
Name: grant_dst_router

Overview:
- 1-to-4 demultiplexer for the network-wrapped grant channel. It is the receiving-end counterpart of the 4-to-1 locking grant arbiter.
- Accepts one stream of headered grant beats and steers each beat to one of four client ports selected by header_dst.
- Multi-beat data grants are locked to a single destination until the last beat has been delivered.
- Sits between the manager-side grant network and the per-client grant queues.

Parameters:
- DATA_BEATS, 8, beats per data-carrying grant; power of 2, range 2..8; beat counter width is log2(DATA_BEATS).
- FIFO_DEPTH, 2, input buffer entries; fixed at 2 in this revision.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous assert, active-low reset
- io_in_valid  in  1  input beat valid
- io_in_ready  out  1  input beat accepted when high together with valid
- io_in_bits_header_src  in  2  source node
- io_in_bits_header_dst  in  2  destination port 0..3
- io_in_bits_payload_addr_beat  in  3  beat index
- io_in_bits_payload_client_xact_id  in  1  client transaction id
- io_in_bits_payload_manager_xact_id  in  2  manager transaction id
- io_in_bits_payload_is_builtin_type  in  1  built-in type flag
- io_in_bits_payload_g_type  in  4  grant type
- io_in_bits_payload_data  in  64  beat data
- io_out_N_valid  out  1  (N=0..3) beat offered to port N
- io_out_N_ready  in  1  (N=0..3) port N accepts the beat
- io_out_bits_*  out  same widths as io_in_bits_*  head-entry fields, shared by all four ports
- io_locked  out  1  a multi-beat burst is in progress
- io_lock_dst  out  2  destination held for the current burst
- io_err  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, reset_n low):
  - FIFO is emptied; beat_cnt, lock, lock_dst and err are cleared.
  - All io_out_N_valid = 0; io_in_ready = 1 once reset_n is released; io_locked = 0; io_lock_dst = 0; io_err = 0.
  - io_out_bits are don't-care while no output is valid.
- Input FIFO:
  - 2 entries, stored in registers.
  - io_in_ready = (count < 2). It is registered-state only and never depends on any io_out_N_ready.
  - Enqueue fires on io_in_valid & io_in_ready.
  - Minimum latency is 1 cycle: a beat accepted in cycle t is offered at the outputs in cycle t+1.
  - Enqueue and dequeue in the same cycle with count 1 leaves count at 1.
  - At count 2, io_in_ready = 0 even if a dequeue happens that cycle.
  - Order is preserved.
- Routing:
  - sel = io_locked ? lock_dst : head.header_dst.
  - io_out_N_valid = (count != 0) & (sel == N). Only one port is valid at a time.
  - Dequeue fires on io_out_sel_valid & io_out_sel_ready.
  - Ready on any non-selected port is ignored.
  - Valid and bits stay stable until the dequeue fires.
- Data-carrying test:
  - hasData = is_builtin_type ? (g_type == 4'h5) : (g_type == 4'h0).
  - This is the same rule the arbiter uses to lock its grant channel.
- Lock and beat counter (updated on dequeue only):
  - Unlocked, dequeued beat with hasData: beat_cnt <= 1, lock_dst <= head.header_dst, io_locked <= 1.
  - Unlocked, dequeued beat without hasData: no state change (single-beat grant).
  - Locked, any dequeued beat: beat_cnt <= beat_cnt + 1 mod DATA_BEATS.
  - Locked, when the increment wraps to 0: io_locked <= 0.
  - While locked, a dequeued beat with !hasData or header_dst != lock_dst sets err.
    - The beat is still delivered to lock_dst and still counted.
- io_err:
  - Sticky; cleared only by reset.
  - The router never stalls or drops a beat because of an error.
- Lock boundary: the final burst beat and the next message's first beat can dequeue on consecutive cycles. The next beat routes by its own header_dst in the cycle after unlock.
- Reset mid-burst: lock and FIFO contents are discarded immediately; there is no partial-burst recovery.

Test Plan:
- Single-beat routing: after reset, send builtin g_type=4'h1 beats with dst=0,1,2,3, all readies high. Required: each beat appears on the matching port one cycle after acceptance; io_locked stays 0; io_err stays 0.
- 8-beat burst: send non-builtin g_type=0, dst=2, data=0..7, port 2 ready high. Required:
  - io_locked rises after beat 0 dequeues, with io_lock_dst = 2.
  - io_locked falls after beat 7 dequeues.
  - Port 2 receives data 0..7 in order; ports 0, 1 and 3 never go valid.
- Backpressure: io_out_1_ready low while 3 beats with dst=1 are sent. Required:
  - io_in_ready drops after 2 acceptances.
  - Port 1 holds valid with stable bits.
  - Raising ready drains both entries in order, and the third beat is then accepted.
- Mid-burst dst mismatch: in an 8-beat dst=0 burst, beat 3 carries dst=3. Required: beat 3 is delivered on port 0; io_err = 1 and stays 1; the burst still ends after 8 beats.
- Back-to-back: a burst to dst=1 immediately followed by a single beat to dst=3. Required: the single beat goes valid on port 3 in the cycle after the last burst beat dequeues, with no bubble beyond that.
- Async reset during a burst: assert reset_n low after beat 4, off a clock edge. Required: all valids, io_locked and io_err go to 0 immediately. After release, a dst=2 single beat routes to port 2.
